// File: rtl/pipeline_controller.sv
// Control unit for the 5-stage ARM-subset pipeline: D-stage decode, D->E->M->W control registers,
// NZCV flags and E-stage condition check. Define PIPE_CTRL_BL_EN to enable branch-with-link (R14 write).
module pipeline_controller #(
  parameter int unsigned          ALU_CMD_W = 4,
  parameter logic [ALU_CMD_W-1:0] ALU_ADD   = ALU_CMD_W'(4'b0100),
  parameter logic [ALU_CMD_W-1:0] ALU_SUB   = ALU_CMD_W'(4'b0010)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic                 N_in,
  input  logic                 Z_in,
  input  logic                 CO_in,
  input  logic                 OVF_in,
  input  logic                 FlushE,
  output logic [1:0]           ImmSrcD,
  output logic [1:0]           RegSrc,
  output logic [ALU_CMD_W-1:0] ALUControlE,
  output logic [1:0]           ALUSrcE,
  output logic                 shifter_control,
  output logic                 BranchTakenE,
  output logic                 MemWriteM,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic                 PCSrcW,
  output logic                 RegSrcZeroW,
  output logic                 RegWriteM,
  output logic                 MemtoRegE,
  output logic                 PCWrPendingF
);

  typedef enum logic [3:0] {
    CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010, CC_CC = 4'b0011,
    CC_MI = 4'b0100, CC_PL = 4'b0101, CC_VS = 4'b0110, CC_VC = 4'b0111,
    CC_HI = 4'b1000, CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011,
    CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110, CC_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 branch;
    logic                 link;
    logic                 flag_write;
    logic                 pc_src;
    logic                 shifter_ctl;
    logic [ALU_CMD_W-1:0] alu_ctl;
    logic [1:0]           alu_src;
    cond_e                cond;
  } ctrl_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  ctrl_t      ctrl_d, ctrl_e;
  logic [3:0] cmd;
  logic [3:0] nzcv;
  logic       n, z, c, v;
  logic       cond_ex;
  logic       mem_to_reg_m, pc_src_m, link_m;
  logic       link_w;

  assign cmd          = Funct[4:1];
  assign {n, z, c, v} = nzcv;

  // NOTE: every signal driven here gets a default first, so no decode path can infer a latch.
  always_comb begin
    ctrl_d      = '0;
    ctrl_d.cond = cond_e'(Cond);
    ImmSrcD     = 2'b00;
    RegSrc      = 2'b00;
    case (Op)
      OP_DP: begin
        ctrl_d.reg_write   = (cmd != CMD_CMP);
        ctrl_d.flag_write  = Funct[0] | (cmd == CMD_CMP);
        ctrl_d.alu_ctl     = (cmd == CMD_CMP) ? ALU_SUB : ALU_CMD_W'(cmd);
        ctrl_d.alu_src     = 2'b10;
        ctrl_d.shifter_ctl = Funct[5];
      end
      OP_MEM: begin
        ctrl_d.alu_src = 2'b01;
        ctrl_d.alu_ctl = ALU_ADD;
        ImmSrcD        = 2'b01;
        if (Funct[0]) begin
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.mem_to_reg = 1'b1;
        end else begin
          ctrl_d.mem_write = 1'b1;
          RegSrc[1]        = 1'b1;
        end
      end
      OP_BR: begin
        ctrl_d.branch  = 1'b1;
        ctrl_d.alu_src = 2'b01;
        ctrl_d.alu_ctl = ALU_ADD;
        ImmSrcD        = 2'b10;
        RegSrc[0]      = 1'b1;
`ifdef PIPE_CTRL_BL_EN
        ctrl_d.link      = Funct[4];
        ctrl_d.reg_write = Funct[4];
`endif
      end
      default: ;
    endcase
    // A link write targets R14, so a BL never redirects the PC even with Rd field 15.
    ctrl_d.pc_src = ctrl_d.reg_write & (Rd == 4'd15) & ~ctrl_d.branch;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || FlushE) begin
      ctrl_e      <= '0;
      ctrl_e.cond <= CC_AL;
    end else begin
      ctrl_e <= ctrl_d;
    end
  end

  always_comb begin
    cond_ex = 1'b0;
    case (ctrl_e.cond)
      CC_EQ: cond_ex = z;
      CC_NE: cond_ex = ~z;
      CC_CS: cond_ex = c;
      CC_CC: cond_ex = ~c;
      CC_MI: cond_ex = n;
      CC_PL: cond_ex = ~n;
      CC_VS: cond_ex = v;
      CC_VC: cond_ex = ~v;
      CC_HI: cond_ex = c & ~z;
      CC_LS: cond_ex = ~c | z;
      CC_GE: cond_ex = (n == v);
      CC_LT: cond_ex = (n != v);
      CC_GT: cond_ex = ~z & (n == v);
      CC_LE: cond_ex = z | (n != v);
      CC_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flags are written at the edge that retires the E instruction; FlushE only bubbles the incoming one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nzcv <= 4'b0000;
    end else if (ctrl_e.flag_write && cond_ex) begin
      nzcv <= {N_in, Z_in, CO_in, OVF_in};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteM    <= 1'b0;
      MemWriteM    <= 1'b0;
      mem_to_reg_m <= 1'b0;
      pc_src_m     <= 1'b0;
      link_m       <= 1'b0;
      RegWriteW    <= 1'b0;
      MemtoRegW    <= 1'b0;
      PCSrcW       <= 1'b0;
      link_w       <= 1'b0;
    end else begin
      RegWriteM    <= ctrl_e.reg_write & cond_ex;
      MemWriteM    <= ctrl_e.mem_write & cond_ex;
      mem_to_reg_m <= ctrl_e.mem_to_reg;
      pc_src_m     <= ctrl_e.pc_src & cond_ex;
      link_m       <= ctrl_e.link & cond_ex;
      RegWriteW    <= RegWriteM;
      MemtoRegW    <= mem_to_reg_m;
      PCSrcW       <= pc_src_m;
      link_w       <= link_m;
    end
  end

  assign ALUControlE     = ctrl_e.alu_ctl;
  assign ALUSrcE         = ctrl_e.alu_src;
  assign shifter_control = ctrl_e.shifter_ctl;
  assign MemtoRegE       = ctrl_e.mem_to_reg;
  assign BranchTakenE    = ctrl_e.branch & cond_ex;
  assign RegSrcZeroW     = link_w;
  // The E term is left ungated so fetch stalls conservatively before the condition resolves.
  assign PCWrPendingF    = ctrl_d.pc_src | ctrl_e.pc_src | pc_src_m;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: per-instruction stage model plus hand-computed spot checks.
module tb_pipeline_controller;

  typedef struct packed {
    logic       rw, mw, m2r, br, link, fw, pcs, sh;
    logic [3:0] alu, cond;
    logic [1:0] src, imm, regsrc;
  } exp_t;

`ifdef PIPE_CTRL_BL_EN
  localparam bit BL_ON = 1'b1;
`else
  localparam bit BL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Cond, Rd;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       N_in, Z_in, CO_in, OVF_in, FlushE;
  logic [1:0] ImmSrcD, RegSrc, ALUSrcE;
  logic [3:0] ALUControlE;
  logic       shifter_control, BranchTakenE, MemWriteM, RegWriteW, MemtoRegW;
  logic       PCSrcW, RegSrcZeroW, RegWriteM, MemtoRegE, PCWrPendingF;

  int total = 0;
  int bad = 0;

  exp_t       e_s, m_s, w_s, cmp_d;
  logic       m_ok, w_ok;
  logic [3:0] flags;

  pipeline_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .N_in(N_in), .Z_in(Z_in), .CO_in(CO_in), .OVF_in(OVF_in), .FlushE(FlushE),
    .ImmSrcD(ImmSrcD), .RegSrc(RegSrc), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .shifter_control(shifter_control), .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .RegSrcZeroW(RegSrcZeroW),
    .RegWriteM(RegWriteM), .MemtoRegE(MemtoRegE), .PCWrPendingF(PCWrPendingF)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction meaning straight from the decode rules.
  function automatic exp_t dec(input logic [3:0] c, input logic [1:0] op,
                               input logic [5:0] f, input logic [3:0] rd);
    exp_t x;
    logic is_cmp;
    x = '0;
    x.cond = c;
    is_cmp = (f[4:1] == 4'b1010);
    if (op == 2'd0) begin
      x.rw = !is_cmp; x.fw = f[0] || is_cmp; x.alu = is_cmp ? 4'b0010 : f[4:1];
      x.src = 2'd2; x.sh = f[5];
    end else if (op == 2'd1) begin
      x.src = 2'd1; x.imm = 2'd1; x.alu = 4'b0100;
      if (f[0]) begin x.rw = 1'b1; x.m2r = 1'b1; end
      else begin x.mw = 1'b1; x.regsrc = 2'b10; end
    end else if (op == 2'd2) begin
      x.br = 1'b1; x.src = 2'd1; x.imm = 2'd2; x.regsrc = 2'b01; x.alu = 4'b0100;
      x.link = BL_ON && f[4]; x.rw = BL_ON && f[4];
    end
    x.pcs = x.rw && (rd == 4'd15) && !x.br;
    return x;
  endfunction

  function automatic exp_t bubble();
    exp_t x;
    x = '0;
    x.cond = 4'b1110;
    return x;
  endfunction

  // Codes 0..13 come in complementary pairs: odd code = NOT(even code).
  function automatic logic pass(input logic [3:0] c, input logic [3:0] f);
    logic fn, fz, fc, fv, base;
    {fn, fz, fc, fv} = f;
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return 1'b0;
    case (c[3:1])
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fn;
      3'd3: base = fv;
      3'd4: base = fc && !fz;
      3'd5: base = (fn == fv);
      default: base = !fz && (fn == fv);
    endcase
    return c[0] ? !base : base;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_s <= bubble(); m_s <= bubble(); w_s <= bubble();
      m_ok <= 1'b0; w_ok <= 1'b0; flags <= 4'b0000;
    end else begin
      if (e_s.fw && pass(e_s.cond, flags)) flags <= {N_in, Z_in, CO_in, OVF_in};
      w_s <= m_s; w_ok <= m_ok;
      m_s <= e_s; m_ok <= pass(e_s.cond, flags);
      e_s <= FlushE ? bubble() : dec(Cond, Op, Funct, Rd);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      cmp_d = dec(Cond, Op, Funct, Rd);
      check("ImmSrcD", 32'(ImmSrcD), 32'(cmp_d.imm));
      check("RegSrc", 32'(RegSrc), 32'(cmp_d.regsrc));
      check("ALUControlE", 32'(ALUControlE), 32'(e_s.alu));
      check("ALUSrcE", 32'(ALUSrcE), 32'(e_s.src));
      check("shifter_control", 32'(shifter_control), 32'(e_s.sh));
      check("MemtoRegE", 32'(MemtoRegE), 32'(e_s.m2r));
      check("BranchTakenE", 32'(BranchTakenE), 32'(e_s.br && pass(e_s.cond, flags)));
      check("RegWriteM", 32'(RegWriteM), 32'(m_s.rw && m_ok));
      check("MemWriteM", 32'(MemWriteM), 32'(m_s.mw && m_ok));
      check("RegWriteW", 32'(RegWriteW), 32'(w_s.rw && w_ok));
      check("MemtoRegW", 32'(MemtoRegW), 32'(w_s.m2r));
      check("PCSrcW", 32'(PCSrcW), 32'(w_s.pcs && w_ok));
      check("RegSrcZeroW", 32'(RegSrcZeroW), 32'(w_s.link && w_ok));
      check("PCWrPendingF", 32'(PCWrPendingF),
            32'(cmp_d.pcs || e_s.pcs || (m_s.pcs && m_ok)));
    end
  end

  task automatic drive(input logic [3:0] c, input logic [1:0] op,
                       input logic [5:0] f, input logic [3:0] rd);
    Cond = c; Op = op; Funct = f; Rd = rd;
  endtask

  task automatic nop();
    drive(4'b1110, 2'b11, 6'b000000, 4'd0);
  endtask

  task automatic set_flags(input logic [3:0] f);
    {N_in, Z_in, CO_in, OVF_in} = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_RegWriteM"}, 32'(RegWriteM), 32'd0);
    check({tag, "_MemWriteM"}, 32'(MemWriteM), 32'd0);
    check({tag, "_RegWriteW"}, 32'(RegWriteW), 32'd0);
    check({tag, "_MemtoRegW"}, 32'(MemtoRegW), 32'd0);
    check({tag, "_PCSrcW"}, 32'(PCSrcW), 32'd0);
    check({tag, "_RegSrcZeroW"}, 32'(RegSrcZeroW), 32'd0);
    check({tag, "_ALUControlE"}, 32'(ALUControlE), 32'd0);
    check({tag, "_ALUSrcE"}, 32'(ALUSrcE), 32'd0);
    check({tag, "_shifter"}, 32'(shifter_control), 32'd0);
    check({tag, "_MemtoRegE"}, 32'(MemtoRegE), 32'd0);
    check({tag, "_BranchTakenE"}, 32'(BranchTakenE), 32'd0);
  endtask

  initial begin
    FlushE = 1'b0;
    nop();
    set_flags(4'b0000);
    #1 reset = 1'b0;
    #2 reset_checks("por");
    #9 reset = 1'b1;
    tick();

    // ADD R1,R2,#5
    drive(4'b1110, 2'b00, 6'b101000, 4'd1);
    #1 check("add_ImmSrcD", 32'(ImmSrcD), 32'd0);
    tick();
    check("add_ALUControlE", 32'(ALUControlE), 32'h4);
    check("add_ALUSrcE", 32'(ALUSrcE), 32'h2);
    check("add_shifter", 32'(shifter_control), 32'd1);
    nop(); tick();
    check("add_RegWriteM", 32'(RegWriteM), 32'd1);
    tick();
    check("add_RegWriteW", 32'(RegWriteW), 32'd1);
    check("add_MemtoRegW", 32'(MemtoRegW), 32'd0);

    // CMP sets Z, BEQ taken
    drive(4'b1110, 2'b00, 6'b110101, 4'd0); tick();
    set_flags(4'b0100);
    drive(4'b0000, 2'b10, 6'b100000, 4'd0); tick();
    check("beq_taken", 32'(BranchTakenE), 32'd1);
    check("cmp_no_write", 32'(RegWriteM), 32'd0);
    nop(); set_flags(4'b0000); tick();

    // CMP clears Z, BEQ not taken, ADDEQ suppressed
    drive(4'b1110, 2'b00, 6'b110101, 4'd0); tick();
    set_flags(4'b0000);
    drive(4'b0000, 2'b10, 6'b100000, 4'd0); tick();
    check("beq_not_taken", 32'(BranchTakenE), 32'd0);
    drive(4'b0000, 2'b00, 6'b101000, 4'd2); tick();
    nop(); tick();
    check("addeq_RegWriteM", 32'(RegWriteM), 32'd0);
    tick();
    check("addeq_RegWriteW", 32'(RegWriteW), 32'd0);

    // LDR then STR
    drive(4'b1110, 2'b01, 6'b011001, 4'd4);
    #1 check("ldr_ImmSrcD", 32'(ImmSrcD), 32'd1);
    tick();
    check("ldr_MemtoRegE", 32'(MemtoRegE), 32'd1);
    drive(4'b1110, 2'b01, 6'b011000, 4'd5);
    #1 check("str_RegSrc", 32'(RegSrc), 32'h2);
    tick();
    nop(); tick();
    check("str_MemWriteM", 32'(MemWriteM), 32'd1);
    check("ldr_RegWriteW", 32'(RegWriteW), 32'd1);
    check("ldr_MemtoRegW", 32'(MemtoRegW), 32'd1);
    tick();
    check("str_RegWriteW", 32'(RegWriteW), 32'd0);

    // MOV PC,R3
    drive(4'b1110, 2'b00, 6'b011010, 4'd15);
    #1 check("mov_pend_D", 32'(PCWrPendingF), 32'd1);
    tick();
    check("mov_pend_E", 32'(PCWrPendingF), 32'd1);
    nop(); tick();
    check("mov_pend_M", 32'(PCWrPendingF), 32'd1);
    tick();
    check("mov_pend_W", 32'(PCWrPendingF), 32'd0);
    check("mov_PCSrcW", 32'(PCSrcW), 32'd1);

    // BL with Rd field 15
    drive(4'b1110, 2'b10, 6'b110000, 4'd15);
    #1 check("bl_no_pend", 32'(PCWrPendingF), 32'd0);
    check("bl_RegSrc", 32'(RegSrc), 32'h1);
    check("bl_ImmSrcD", 32'(ImmSrcD), 32'h2);
    tick();
    check("bl_taken", 32'(BranchTakenE), 32'd1);
    nop(); tick(); tick();
    check("bl_RegSrcZeroW", 32'(RegSrcZeroW), 32'(BL_ON));
    check("bl_RegWriteW", 32'(RegWriteW), 32'(BL_ON));
    check("bl_PCSrcW", 32'(PCSrcW), 32'd0);

    // Flushed ADDS: bubble, flags untouched
    set_flags(4'b1111); FlushE = 1'b1;
    drive(4'b1110, 2'b00, 6'b101001, 4'd6); tick();
    check("flush_ALUSrcE", 32'(ALUSrcE), 32'd0);
    check("flush_ALUControlE", 32'(ALUControlE), 32'd0);
    FlushE = 1'b0;
    drive(4'b0000, 2'b10, 6'b100000, 4'd0); tick();
    check("flush_flags_kept", 32'(BranchTakenE), 32'd0);
    check("flush_RegWriteM", 32'(RegWriteM), 32'd0);
    nop(); set_flags(4'b0000); tick();
    check("flush_RegWriteW", 32'(RegWriteW), 32'd0);

    // ADDS in E while FlushE bubbles the next one
    drive(4'b1110, 2'b00, 6'b101001, 4'd6); tick();
    FlushE = 1'b1; set_flags(4'b0100);
    drive(4'b1110, 2'b00, 6'b101000, 4'd7); tick();
    check("flushE_bubble", 32'(ALUControlE), 32'd0);
    check("adds_RegWriteM", 32'(RegWriteM), 32'd1);
    FlushE = 1'b0; set_flags(4'b0000);
    drive(4'b0000, 2'b10, 6'b100000, 4'd0); tick();
    check("adds_flags_set", 32'(BranchTakenE), 32'd1);
    check("flushed_RegWriteM", 32'(RegWriteM), 32'd0);
    nop(); tick();

    // Every condition code against every flag pattern
    for (int p = 0; p < 16; p++) begin
      for (int c = 0; c < 16; c++) begin
        drive(4'b1110, 2'b00, 6'b110101, 4'd0); tick();
        set_flags(4'(p));
        drive(4'(c), 2'b10, 6'b100000, 4'd0); tick();
        if (p == 8 && c == 11) check("lt_taken", 32'(BranchTakenE), 32'd1);
        if (p == 6 && c == 8) check("hi_z_set", 32'(BranchTakenE), 32'd0);
        if (c == 15) check("nv_never", 32'(BranchTakenE), 32'd0);
      end
    end
    nop(); set_flags(4'b0000); tick();

    // Asynchronous reset mid-stream with RegWriteM high and Z set
    set_flags(4'b0100);
    drive(4'b1110, 2'b00, 6'b110101, 4'd0); tick();
    drive(4'b1110, 2'b00, 6'b101000, 4'd1); tick();
    nop(); set_flags(4'b0000); tick();
    check("pre_reset_RegWriteM", 32'(RegWriteM), 32'd1);
    #2 reset = 1'b0;
    #1 reset_checks("async");
    drive(4'b0000, 2'b10, 6'b100000, 4'd0);
    #4 reset = 1'b1;
    tick();
    check("reset_clears_Z", 32'(BranchTakenE), 32'd0);
    nop(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
